// File: rtl/usb_data_fifo.sv
// Parametrised circular FIFO between the AHB-lite push side and a USB packet engine pop side.
// Optional sticky overflow/underflow outputs are enabled with `define USB_FIFO_ERR_FLAGS_EN.
module usb_data_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 64,
    parameter int AF_LEVEL = 56,
    parameter int OCC_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [OCC_W-1:0]  occupancy,
    output logic              full,
    output logic              empty,
    output logic              almost_full
`ifdef USB_FIFO_ERR_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_occ;
    logic [OCC_W-1:0]  w_occ_nxt;
    logic              w_full;
    logic              w_empty;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign w_full  = (r_occ == OCC_W'(DEPTH));
    assign w_empty = (r_occ == '0);

    // A pop at full frees the slot on the same edge, so the push is still taken.
    assign w_pop_ok  = pop & ~w_empty;
    assign w_push_ok = push & (~w_full | w_pop_ok);

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_push_ok && !w_pop_ok)
            w_occ_nxt = r_occ + OCC_W'(1);
        else if (!w_push_ok && w_pop_ok)
            w_occ_nxt = r_occ - OCC_W'(1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_occ <= w_occ_nxt;
        end
    end

    // Storage is not reset; only entries between the pointers are ever observable.
    always_ff @(posedge clk) begin
        if (w_push_ok && !clear)
            r_mem[r_wr_ptr] <= push_data;
    end

    assign pop_data    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign occupancy   = r_occ;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (r_occ >= OCC_W'(AF_LEVEL));

`ifdef USB_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push && w_full && !pop)
                r_overflow <= 1'b1;
            if (pop && w_empty)
                r_underflow <= 1'b1;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_usb_data_fifo.sv
// Randomised self-checking bench for usb_data_fifo against a queue-based reference model.
// Exercises the default 8x64 instance and a 16x8 instance; flag checks follow USB_FIFO_ERR_FLAGS_EN.
module tb_usb_data_fifo;

    localparam int DP = 64;
    localparam int AF = 56;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       clear = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] push_data = '0;
    logic [7:0] pop_data;
    logic [6:0] occupancy;
    logic       full, empty, almost_full;

    logic        s_clear = 1'b0;
    logic        s_push = 1'b0;
    logic        s_pop = 1'b0;
    logic [15:0] s_pd = '0;
    logic [15:0] s_pdo;
    logic [3:0]  s_occ;
    logic        s_full, s_empty, s_af;

`ifdef USB_FIFO_ERR_FLAGS_EN
    logic overflow, underflow, s_ovf, s_unf;
`endif

    usb_data_fifo dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .push(push), .push_data(push_data),
        .pop(pop), .pop_data(pop_data), .occupancy(occupancy), .full(full),
        .empty(empty), .almost_full(almost_full)
`ifdef USB_FIFO_ERR_FLAGS_EN
        , .overflow(overflow), .underflow(underflow)
`endif
    );

    usb_data_fifo #(.DATA_W(16), .DEPTH(8), .AF_LEVEL(6)) dut8 (
        .clk(clk), .n_rst(n_rst), .clear(s_clear), .push(s_push), .push_data(s_pd),
        .pop(s_pop), .pop_data(s_pdo), .occupancy(s_occ), .full(s_full),
        .empty(s_empty), .almost_full(s_af)
`ifdef USB_FIFO_ERR_FLAGS_EN
        , .overflow(s_ovf), .underflow(s_unf)
`endif
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    logic [7:0] q[$];
    bit         m_ovf = 0;
    bit         m_unf = 0;

    function automatic logic [7:0] m_head();
        return (q.size() > 0) ? q[0] : 8'h00;
    endfunction

    // Drive one cycle on the main instance and advance the reference model at the edge.
    task automatic step(input bit ps, input logic [7:0] d, input bit pp, input bit cl);
        push = ps; push_data = d; pop = pp; clear = cl;
        @(posedge clk);
        if (cl) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (ps && !pp && q.size() == DP) m_ovf = 1;
            if (pp && q.size() == 0) m_unf = 1;
            if (pp && q.size() > 0) void'(q.pop_front());
            if (ps && q.size() < DP) q.push_back(d);
        end
        #1;
        push = 0; pop = 0; clear = 0;
    endtask

    task automatic test_reset();
        n_rst = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (occupancy !== 7'd0) begin errs++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        checks++; if ({empty, full, almost_full} !== 3'b100) begin errs++; $display("FAIL reset_flags: got e/f/af=%b want 100", {empty, full, almost_full}); end
        checks++; if (pop_data !== 8'h00) begin errs++; $display("FAIL reset_pop_data: got %h want 00", pop_data); end
        checks++; if (s_occ !== 4'd0 || s_empty !== 1'b1) begin errs++; $display("FAIL reset_small: got occ=%0d empty=%b want 0/1", s_occ, s_empty); end
`ifdef USB_FIFO_ERR_FLAGS_EN
        checks++; if ({overflow, underflow} !== 2'b00) begin errs++; $display("FAIL reset_err: got %b want 00", {overflow, underflow}); end
`endif
        n_rst = 1;
        repeat (2) step(0, 0, 0, 0);
        checks++; if (occupancy !== 7'd0 || pop_data !== 8'h00) begin errs++; $display("FAIL idle: got occ=%0d data=%h want 0/00", occupancy, pop_data); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DP; i++) begin
            step(1, 8'(i), 0, 0);
            checks++;
            if (occupancy !== 7'(q.size()) || almost_full !== (q.size() >= AF) ||
                full !== (q.size() == DP) || empty !== 1'b0 || pop_data !== 8'h01) begin
                errs++;
                $display("FAIL fill_%0d: got occ=%0d af=%b full=%b empty=%b head=%h want occ=%0d af=%b full=%b head=01",
                         i, occupancy, almost_full, full, empty, pop_data, q.size(), q.size() >= AF, q.size() == DP);
            end
        end
        step(1, 8'hFF, 0, 0);
        checks++; if (occupancy !== 7'd64 || full !== 1'b1 || pop_data !== 8'h01) begin errs++; $display("FAIL push_full_drop: got occ=%0d full=%b head=%h want 64/1/01", occupancy, full, pop_data); end
`ifdef USB_FIFO_ERR_FLAGS_EN
        checks++; if (overflow !== 1'b1 || underflow !== 1'b0) begin errs++; $display("FAIL overflow_set: got ovf=%b unf=%b want 1/0", overflow, underflow); end
`endif
    endtask

    task automatic test_drain();
        logic [7:0] exp;
        for (int i = 0; i < DP; i++) begin
            exp = m_head();
            checks++; if (pop_data !== exp || exp !== 8'(i + 1)) begin errs++; $display("FAIL drain_%0d: got %h want %h", i, pop_data, 8'(i + 1)); end
            step(0, 0, 1, 0);
        end
        checks++; if (empty !== 1'b1 || occupancy !== 7'd0 || almost_full !== 1'b0) begin errs++; $display("FAIL drain_empty: got empty=%b occ=%0d af=%b want 1/0/0", empty, occupancy, almost_full); end
        step(0, 0, 1, 0);
        checks++; if (pop_data !== 8'h00 || occupancy !== 7'd0) begin errs++; $display("FAIL pop_empty: got data=%h occ=%0d want 00/0", pop_data, occupancy); end
`ifdef USB_FIFO_ERR_FLAGS_EN
        checks++; if (underflow !== 1'b1 || overflow !== 1'b1) begin errs++; $display("FAIL underflow_set: got unf=%b ovf=%b want 1/1", underflow, overflow); end
`endif
    endtask

    task automatic test_stream();
        logic [7:0] cnt = 8'h10;
        int         bad = 0;
        for (int i = 0; i < 3; i++) begin step(1, cnt, 0, 0); cnt++; end
        for (int i = 0; i < 200; i++) begin
            if (pop_data !== m_head() || pop_data !== cnt - 8'd3) bad++;
            step(1, cnt, 1, 0);
            cnt++;
            if (occupancy !== 7'd3) bad++;
        end
        checks++; if (bad != 0) begin errs++; $display("FAIL stream: got %0d bad cycles want 0", bad); end
        checks++; if (pop_data !== cnt - 8'd3) begin errs++; $display("FAIL stream_head: got %h want %h", pop_data, cnt - 8'd3); end
        step(0, 0, 0, 1);
    endtask

    task automatic test_full_simul();
        logic [7:0] exp;
        logic [7:0] last;
        for (int i = 0; i < DP; i++) step(1, 8'($urandom), 0, 0);
        exp = m_head();
        checks++; if (pop_data !== exp) begin errs++; $display("FAIL full_head: got %h want %h", pop_data, exp); end
        step(1, 8'hAA, 1, 0);
        checks++; if (occupancy !== 7'd64 || full !== 1'b1) begin errs++; $display("FAIL full_pushpop: got occ=%0d full=%b want 64/1", occupancy, full); end
        last = 8'h00;
        for (int i = 0; i < DP; i++) begin
            exp = m_head();
            checks++; if (pop_data !== exp) begin errs++; $display("FAIL full_drain_%0d: got %h want %h", i, pop_data, exp); end
            last = pop_data;
            step(0, 0, 1, 0);
        end
        checks++; if (last !== 8'hAA || empty !== 1'b1) begin errs++; $display("FAIL full_last: got %h empty=%b want AA/1", last, empty); end
        checks++; if (pop_data !== 8'h00) begin errs++; $display("FAIL empty_no_bypass_pre: got %h want 00", pop_data); end
        push = 1; push_data = 8'h55; pop = 1;
        #1;
        checks++; if (pop_data !== 8'h00) begin errs++; $display("FAIL empty_no_bypass: got %h want 00", pop_data); end
        step(1, 8'h55, 1, 0);
        checks++; if (occupancy !== 7'd1 || pop_data !== 8'h55) begin errs++; $display("FAIL empty_pushpop: got occ=%0d data=%h want 1/55", occupancy, pop_data); end
    endtask

    task automatic test_clear();
        while (q.size() < 10) step(1, 8'($urandom), 0, 0);
        checks++; if (occupancy !== 7'd10) begin errs++; $display("FAIL pre_clear: got %0d want 10", occupancy); end
        step(1, 8'h77, 1, 1);
        checks++; if (occupancy !== 7'd0 || empty !== 1'b1 || pop_data !== 8'h00) begin errs++; $display("FAIL clear: got occ=%0d empty=%b data=%h want 0/1/00", occupancy, empty, pop_data); end
`ifdef USB_FIFO_ERR_FLAGS_EN
        checks++; if ({overflow, underflow} !== 2'b00) begin errs++; $display("FAIL clear_err: got %b want 00", {overflow, underflow}); end
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        checks++; if (underflow !== 1'b0) begin errs++; $display("FAIL clear_wins: got unf=%b want 0", underflow); end
`endif
        step(1, 8'h3C, 0, 0);
        checks++; if (pop_data !== 8'h3C || occupancy !== 7'd1) begin errs++; $display("FAIL post_clear: got data=%h occ=%0d want 3C/1", pop_data, occupancy); end
    endtask

    task automatic test_random();
        int  bad = 0;
        bit  ps, pp, cl;
        for (int i = 0; i < 2000; i++) begin
            ps = ($urandom_range(0, 99) < ((i / 250) % 2 ? 75 : 35));
            pp = ($urandom_range(0, 99) < ((i / 250) % 2 ? 35 : 75));
            cl = ($urandom_range(0, 199) == 0);
            if (pop_data !== m_head()) bad++;
            step(ps, 8'($urandom), pp, cl);
            if (occupancy !== 7'(q.size()) || full !== (q.size() == DP) ||
                empty !== (q.size() == 0) || almost_full !== (q.size() >= AF)) bad++;
`ifdef USB_FIFO_ERR_FLAGS_EN
            if (overflow !== m_ovf || underflow !== m_unf) bad++;
`endif
        end
        checks++; if (bad != 0) begin errs++; $display("FAIL random: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0);
        #2 n_rst = 0;
        #1;
        q.delete(); m_ovf = 0; m_unf = 0;
        checks++; if (occupancy !== 7'd0 || empty !== 1'b1 || pop_data !== 8'h00) begin errs++; $display("FAIL mid_reset: got occ=%0d empty=%b data=%h want 0/1/00", occupancy, empty, pop_data); end
        #1 n_rst = 1;
        step(1, 8'h9D, 0, 0);
        checks++; if (occupancy !== 7'd1 || pop_data !== 8'h9D) begin errs++; $display("FAIL after_reset: got occ=%0d data=%h want 1/9D", occupancy, pop_data); end
    endtask

    task automatic test_small();
        logic [15:0] sq[$];
        logic [15:0] d;
        for (int i = 0; i < 8; i++) begin
            d = 16'($urandom);
            s_push = 1; s_pd = d;
            @(posedge clk);
            sq.push_back(d);
            #1 s_push = 0;
            checks++; if (s_occ !== 4'(sq.size()) || s_af !== (sq.size() >= 6) || s_pdo !== sq[0]) begin errs++; $display("FAIL small_fill_%0d: got occ=%0d af=%b head=%h want %0d/%b/%h", i, s_occ, s_af, s_pdo, sq.size(), sq.size() >= 6, sq[0]); end
        end
        checks++; if (s_full !== 1'b1) begin errs++; $display("FAIL small_full: got %b want 1", s_full); end
        s_push = 1; s_pd = 16'hDEAD;
        @(posedge clk); #1 s_push = 0;
        checks++; if (s_occ !== 4'd8 || s_pdo !== sq[0]) begin errs++; $display("FAIL small_drop: got occ=%0d head=%h want 8/%h", s_occ, s_pdo, sq[0]); end
`ifdef USB_FIFO_ERR_FLAGS_EN
        checks++; if (s_ovf !== 1'b1) begin errs++; $display("FAIL small_ovf: got %b want 1", s_ovf); end
`endif
        for (int i = 0; i < 8; i++) begin
            checks++; if (s_pdo !== sq[0]) begin errs++; $display("FAIL small_drain_%0d: got %h want %h", i, s_pdo, sq[0]); end
            s_pop = 1;
            @(posedge clk);
            void'(sq.pop_front());
            #1 s_pop = 0;
        end
        checks++; if (s_empty !== 1'b1 || s_pdo !== 16'h0000) begin errs++; $display("FAIL small_empty: got empty=%b data=%h want 1/0000", s_empty, s_pdo); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_full_simul();
        test_clear();
        test_random();
        test_mid_reset();
        test_small();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
